// File: rtl/johnson_pkg.sv
// Shared Johnson-code helpers: phase-width sizing, code legality and code-to-phase decode.
// Used by the decoder RTL and by the Johnson counter bench reference model.
package johnson_pkg;

  localparam int unsigned JS_MAX_WID = 64;

  typedef enum logic {
    ST_RESYNC = 1'b0,
    ST_TRACK  = 1'b1
  } trk_state_e;

  function automatic int unsigned ph_wid(input int unsigned n);
    return 32'($clog2(2 * n));
  endfunction

  // Keep only the low n bits of a code carried in a max-width vector.
  function automatic logic [JS_MAX_WID-1:0] js_mask(input int unsigned n);
    return (n >= JS_MAX_WID) ? '1 : ((JS_MAX_WID'(1) << n) - JS_MAX_WID'(1));
  endfunction

  function automatic logic js_legal(input logic [JS_MAX_WID-1:0] code, input int unsigned n);
    logic [JS_MAX_WID-1:0] m;
    logic [JS_MAX_WID-1:0] diff;
    m    = js_mask(n);
    diff = ((code & m) ^ ((code & m) >> 1)) & (m >> 1);
    return $countones(diff) <= 1;
  endfunction

  function automatic int unsigned js_phase(input logic [JS_MAX_WID-1:0] code, input int unsigned n);
    logic [JS_MAX_WID-1:0] c;
    int unsigned           pc;
    logic                  msb;
    c   = code & js_mask(n);
    pc  = 32'($countones(c));
    msb = |(c >> (n - 1));
    return msb ? ((2 * n - pc) % (2 * n)) : pc;
  endfunction

endpackage

// File: rtl/johnson_decoder_if.sv
// Sample/result bundle between a Johnson code source and the decoder.
interface johnson_decoder_if
  import johnson_pkg::*;
#(
  parameter int unsigned DATA_WID    = 8,
  parameter int unsigned PH_WID      = ph_wid(DATA_WID),
  parameter int unsigned ERR_CNT_WID = 8
);
  logic                   en;
  logic [DATA_WID-1:0]    data_in;
  logic [PH_WID-1:0]      phase;
  logic                   phase_vld;
  logic                   legal;
  logic                   wrap;
  logic                   seq_err;
  logic [ERR_CNT_WID-1:0] err_cnt;

  modport master (
    output en, data_in,
    input  phase, phase_vld, legal, wrap, seq_err, err_cnt
  );

  modport slave (
    input  en, data_in,
    output phase, phase_vld, legal, wrap, seq_err, err_cnt
  );
endinterface

// File: rtl/johnson_code_check.sv
// Combinational legality check and phase decode of one Johnson code word.
module johnson_code_check
  import johnson_pkg::*;
#(
  parameter int unsigned DATA_WID = 8,
  parameter int unsigned PH_WID   = ph_wid(DATA_WID)
) (
  input  logic [DATA_WID-1:0] data_i,
  output logic                legal_c_o,
  output logic [PH_WID-1:0]   phase_c_o
);
  logic [JS_MAX_WID-1:0] code_ext;

  assign code_ext  = JS_MAX_WID'(data_i);
  assign legal_c_o = js_legal(code_ext, DATA_WID);
  assign phase_c_o = PH_WID'(js_phase(code_ext, DATA_WID));
endmodule

// File: rtl/johnson_decoder.sv
// Registered Johnson-code decoder with successor checking and sequence-error flagging.
// Define JOHNSON_DECODER_ERR_CNT_EN to build the saturating error counter; otherwise err_cnt is 0.
module johnson_decoder
  import johnson_pkg::*;
#(
  parameter int unsigned DATA_WID    = 8,
  parameter int unsigned PH_WID      = ph_wid(DATA_WID),
  parameter int unsigned ERR_CNT_WID = 8,
  parameter bit          ALLOW_HOLD  = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  johnson_decoder_if.slave  bus
);
  localparam int unsigned PH1_WID = PH_WID + 1;
  localparam int unsigned TWO_N   = 2 * DATA_WID;

  logic                legal_c;
  logic [PH_WID-1:0]   code_ph_c;
  logic [PH1_WID-1:0]  succ_c;
  logic                succ_ok_c;

  trk_state_e          state_q, state_d;
  logic [PH_WID-1:0]   prev_phase_q, prev_phase_d;
  logic [PH_WID-1:0]   phase_q, phase_d;
  logic                legal_q, legal_d;
  logic                phase_vld_q, phase_vld_d;
  logic                wrap_q, wrap_d;
  logic                seq_err_q, seq_err_d;

  johnson_code_check #(
    .DATA_WID (DATA_WID),
    .PH_WID   (PH_WID)
  ) u_code_check (
    .data_i    (bus.data_in),
    .legal_c_o (legal_c),
    .phase_c_o (code_ph_c)
  );

  // Expected successor of the last tracked phase, modulo 2N.
  always_comb begin
    succ_c = PH1_WID'(prev_phase_q) + PH1_WID'(1);
    if (succ_c == PH1_WID'(TWO_N)) succ_c = '0;
    succ_ok_c = (PH1_WID'(code_ph_c) == succ_c) ||
                (ALLOW_HOLD && (code_ph_c == prev_phase_q));
  end

  always_comb begin
    state_d      = state_q;
    prev_phase_d = prev_phase_q;
    phase_d      = phase_q;
    legal_d      = legal_q;
    phase_vld_d  = 1'b0;
    wrap_d       = 1'b0;
    seq_err_d    = 1'b0;
    if (bus.en) begin
      phase_vld_d = 1'b1;
      if (!legal_c) begin
        legal_d   = 1'b0;
        phase_d   = '0;
        seq_err_d = 1'b1;
        state_d   = ST_RESYNC;
      end else begin
        legal_d      = 1'b1;
        phase_d      = code_ph_c;
        prev_phase_d = code_ph_c;
        state_d      = ST_TRACK;
        // A resync sample is taken on trust; only tracked samples are checked.
        if (state_q == ST_TRACK) begin
          seq_err_d = !succ_ok_c;
          wrap_d    = (prev_phase_q == PH_WID'(TWO_N - 1)) && (code_ph_c == '0);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RESYNC;
      prev_phase_q <= '0;
      phase_q      <= '0;
      legal_q      <= 1'b0;
      phase_vld_q  <= 1'b0;
      wrap_q       <= 1'b0;
      seq_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_phase_q <= prev_phase_d;
      phase_q      <= phase_d;
      legal_q      <= legal_d;
      phase_vld_q  <= phase_vld_d;
      wrap_q       <= wrap_d;
      seq_err_q    <= seq_err_d;
    end
  end

`ifdef JOHNSON_DECODER_ERR_CNT_EN
  logic [ERR_CNT_WID-1:0] err_cnt_q, err_cnt_d;

  // Saturating count of flagged samples.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (seq_err_d && !(&err_cnt_q)) err_cnt_d = err_cnt_q + ERR_CNT_WID'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) err_cnt_q <= '0;
    else     err_cnt_q <= err_cnt_d;
  end

  assign bus.err_cnt = err_cnt_q;
`else
  assign bus.err_cnt = ERR_CNT_WID'(0);
`endif

  assign bus.phase     = phase_q;
  assign bus.phase_vld = phase_vld_q;
  assign bus.legal     = legal_q;
  assign bus.wrap      = wrap_q;
  assign bus.seq_err   = seq_err_q;
endmodule

// File: tb/tb_johnson_decoder.sv
// Scoreboard bench for johnson_decoder (N=4, 2-bit error counter), ALLOW_HOLD=0 and =1 side by side.
module tb_johnson_decoder;

  typedef struct packed {
    logic [2:0] phase;
    logic       vld;
    logic       legal;
    logic       wrap;
    logic       err;
    logic [1:0] cnt;
    logic [2:0] prev;
    logic       ok;
  } mdl_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] codes [8] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  mdl_t        m0, m1;
  mdl_t        q0[$];
  mdl_t        q1[$];

  johnson_decoder_if #(.DATA_WID(4), .PH_WID(3), .ERR_CNT_WID(2)) bus0 ();
  johnson_decoder_if #(.DATA_WID(4), .PH_WID(3), .ERR_CNT_WID(2)) bus1 ();

  johnson_decoder #(.DATA_WID(4), .PH_WID(3), .ERR_CNT_WID(2), .ALLOW_HOLD(1'b0)) u_dut0 (
    .clk (clk), .rst (rst), .bus (bus0.slave)
  );
  johnson_decoder #(.DATA_WID(4), .PH_WID(3), .ERR_CNT_WID(2), .ALLOW_HOLD(1'b1)) u_dut1 (
    .clk (clk), .rst (rst), .bus (bus1.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: legality and phase come from a lookup of the 2N legal codes.
  function automatic mdl_t step(input mdl_t m, input logic r, input logic e,
                                input logic [3:0] d, input bit hold);
    mdl_t n;
    int   idx;
    n      = m;
    idx    = -1;
    n.vld  = 1'b0;
    n.wrap = 1'b0;
    n.err  = 1'b0;
    if (r) return '0;
    if (!e) return n;
    for (int i = 0; i < 8; i++) if (codes[i] == d) idx = i;
    n.vld = 1'b1;
    if (idx < 0) begin
      n.legal = 1'b0;
      n.phase = 3'd0;
      n.err   = 1'b1;
      n.ok    = 1'b0;
    end else begin
      n.legal = 1'b1;
      n.phase = 3'(idx);
      if (m.ok) begin
        n.err  = !((3'(idx) == m.prev + 3'd1) || (hold && (3'(idx) == m.prev)));
        n.wrap = (m.prev == 3'd7) && (idx == 0);
      end
      n.prev = 3'(idx);
      n.ok   = 1'b1;
    end
`ifdef JOHNSON_DECODER_ERR_CNT_EN
    if (n.err && (n.cnt != 2'd3)) n.cnt = n.cnt + 2'd1;
`endif
    return n;
  endfunction

  task automatic compare_one(input string who, input mdl_t exp, input logic [2:0] ph,
                             input logic vld, input logic lg, input logic wr,
                             input logic se, input logic [1:0] ec);
    check_eq({who, ".phase"},     32'(ph),  32'(exp.phase));
    check_eq({who, ".phase_vld"}, 32'(vld), 32'(exp.vld));
    check_eq({who, ".legal"},     32'(lg),  32'(exp.legal));
    check_eq({who, ".wrap"},      32'(wr),  32'(exp.wrap));
    check_eq({who, ".seq_err"},   32'(se),  32'(exp.err));
    check_eq({who, ".err_cnt"},   32'(ec),  32'(exp.cnt));
  endtask

  task automatic cyc(input logic r, input logic e, input logic [3:0] d);
    mdl_t x;
    @(negedge clk);
    rst          = r;
    bus0.en      = e;
    bus0.data_in = d;
    bus1.en      = e;
    bus1.data_in = d;
    m0 = step(m0, r, e, d, 1'b0);
    m1 = step(m1, r, e, d, 1'b1);
    q0.push_back(m0);
    q1.push_back(m1);
    @(posedge clk);
    #1;
    if (q0.size() == 0) check_eq("sb0_underflow", 32'd0, 32'd1);
    else begin
      x = q0.pop_front();
      compare_one("hold0", x, bus0.phase, bus0.phase_vld, bus0.legal,
                  bus0.wrap, bus0.seq_err, bus0.err_cnt);
    end
    if (q1.size() == 0) check_eq("sb1_underflow", 32'd0, 32'd1);
    else begin
      x = q1.pop_front();
      compare_one("hold1", x, bus1.phase, bus1.phase_vld, bus1.legal,
                  bus1.wrap, bus1.seq_err, bus1.err_cnt);
    end
  endtask

  initial begin
    logic [3:0] d;
    int         sel;
    m0 = '0;
    m1 = '0;
    rst = 1'b1;
    bus0.en = 1'b0; bus0.data_in = 4'h0;
    bus1.en = 1'b0; bus1.data_in = 4'h0;

    cyc(1'b1, 1'b0, 4'h0);
    cyc(1'b1, 1'b0, 4'h0);

    // Full cycle with wrap on the final sample.
    foreach (codes[i]) cyc(1'b0, 1'b1, codes[i]);
    cyc(1'b0, 1'b1, 4'h0);

    // Illegal code followed by a resync sample.
    cyc(1'b0, 1'b1, 4'h1);
    cyc(1'b0, 1'b1, 4'h3);
    cyc(1'b0, 1'b1, 4'h5);
    cyc(1'b0, 1'b1, 4'hF);

    // Skip, then hold.
    cyc(1'b1, 1'b0, 4'h0);
    cyc(1'b0, 1'b1, 4'h1);
    cyc(1'b0, 1'b1, 4'h7);
    cyc(1'b1, 1'b0, 4'h0);
    cyc(1'b0, 1'b1, 4'h3);
    cyc(1'b0, 1'b1, 4'h3);

    // Enable gaps with changing data.
    cyc(1'b1, 1'b0, 4'h0);
    cyc(1'b0, 1'b1, 4'h1);
    repeat (3) cyc(1'b0, 1'b0, 4'hF);
    cyc(1'b0, 1'b1, 4'h3);
    cyc(1'b0, 1'b0, 4'h3);

    // Error counter saturation.
    cyc(1'b1, 1'b0, 4'h0);
    cyc(1'b0, 1'b1, 4'h5);
    cyc(1'b0, 1'b1, 4'hA);
    cyc(1'b0, 1'b1, 4'h6);
    cyc(1'b0, 1'b1, 4'h9);
    cyc(1'b0, 1'b1, 4'h5);

    // Reset mid-stream overrides an illegal enabled sample.
    cyc(1'b1, 1'b1, 4'h5);
    cyc(1'b0, 1'b1, 4'h7);
    cyc(1'b0, 1'b1, 4'hF);

    // Mixed random traffic biased toward legal successors.
    for (int k = 0; k < 200; k++) begin
      sel = $urandom_range(0, 9);
      if (sel < 6)       d = codes[m0.prev + 3'd1];
      else if (sel == 6) d = codes[m0.prev];
      else if (sel == 7) d = codes[m0.prev + 3'd2];
      else               d = 4'($urandom_range(0, 15));
      cyc(($urandom_range(0, 29) == 0), ($urandom_range(0, 3) != 0), d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/johnson_decoder.md
# johnson_decoder

Downstream consumer of the Johnson counter: samples its DATA_WID-bit Johnson code and produces a registered binary phase index. It also checks code legality and successor order, and flags sequence errors. It sits between the Johnson counter and any phase-driven logic (timing-strobe generation, counter self-check), and is the monitor the Johnson counter bench uses for self-checking instead of `$monitor`.

## Interface
- DATA_WID, 8, Johnson code width N; the code has 2N legal states; N >= 2
- PH_WID, $clog2(2*DATA_WID), phase index width
- ERR_CNT_WID, 8, error counter width
- ALLOW_HOLD, 0, when 1 a repeat of the previous phase is not an error
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  sample strobe; data_in is sampled on a rising clk edge with en=1
- data_in  in  DATA_WID  Johnson code from the counter
- phase  out  PH_WID  decoded phase 0..2N-1; reset 0
- phase_vld  out  1  one-cycle pulse: a sample was taken; reset 0
- legal  out  1  last sample was a legal Johnson code; reset 0
- wrap  out  1  one-cycle pulse on a checked 2N-1 -> 0 transition; reset 0
- seq_err  out  1  one-cycle pulse on illegal code or bad successor; reset 0
- err_cnt  out  ERR_CNT_WID  saturating count of seq_err pulses; reset 0

## Operation
- Code convention (shift-left, ~MSB fed into LSB): phase k for k<=N has the low k bits set and the rest clear. Phase k for k>N has the low k-N bits clear and the rest set. For N=4: 0000=0, 0001=1, 0011=2, 0111=3, 1111=4, 1110=5, 1100=6, 1000=7.
- Legality: at most one adjacent-bit transition, i.e. popcount(d[N-1:1] ^ d[N-2:0]) <= 1.
- Decode: pc = popcount(data_in); phase = MSB ? 2N-pc : pc (modulo 2N, so 0000 gives 0). Arithmetic is PH_WID+1 bits wide, then truncated.
- Internal state: prev_phase (PH_WID bits) and prev_ok (1 bit). prev_ok=1 means the previous sample was legal and taken since reset.
- Each sample with en=1:
  - If data_in is illegal: legal=0, phase=0, seq_err=1, prev_ok<=0.
  - If data_in is legal and prev_ok=0: legal=1, phase=decoded value, seq_err=0. This is the resync sample and it is not checked.
  - If data_in is legal and prev_ok=1: expected = (prev_phase+1) mod 2N. A match is OK. With ALLOW_HOLD=1, equal to prev_phase is also OK. Any other value gives seq_err=1. Then prev_phase<=decoded and prev_ok<=1.
- wrap=1 only when prev_ok=1, prev_phase=2N-1 and the decoded phase is 0.
- err_cnt increments on every seq_err and saturates at all-ones (no wrap).
- With en=0: pulses (phase_vld, wrap, seq_err) are 0. phase, legal, err_cnt and the internal state hold.

## Timing
- Latency 1: a sample taken at edge t has its results on outputs after edge t. All outputs are registered; there is no combinational path from input to output.
- Back-to-back en=1 is supported every cycle, and the throughput is 1 sample/cycle.
- rst=1 overrides en on the same edge. All outputs and the internal state return to their reset values, including prev_ok=0, so the first sample after reset is a resync and is never flagged.
- Reset mid-stream clears err_cnt.
- An illegal sample and the following legal sample give exactly one seq_err. The legal sample is a resync and is not checked.

## Configuration
- JOHNSON_DECODER_ERR_CNT_EN defined: the err_cnt register and saturation logic are built.
- Undefined: err_cnt is tied to 0 and no counter flops exist. seq_err is unaffected.

## Structure
- Shared package johnson_pkg holds:
  - function ph_wid(n) returning $clog2(2n)
  - function js_legal(code)
  - function js_phase(code)
- The Johnson counter bench imports the same functions for its reference model.
- One combinational sub-module, johnson_code_check (data_in -> legal, phase), instantiated once. Its output feeds the registered checker/FSM in johnson_decoder.

## Test plan
- Full cycle: DATA_WID=4, reset, then drive 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000 with en=1 every cycle -> phase 0..7, 0 one cycle later each; wrap=1 only on the final sample; seq_err never 1; err_cnt=0.
- Illegal code: after phase 2 (0011), drive 0101, then 1111 -> 0101 gives legal=0, phase=0, seq_err=1; 1111 gives phase=4, seq_err=0 (resync); err_cnt=1.
- Skip: drive 0001 then 0111 -> seq_err=1 on the second sample, err_cnt=1. With ALLOW_HOLD=1, 0011, 0011 gives no error; with ALLOW_HOLD=0 it gives seq_err=1.
- en gaps: send 0001, then en=0 for 3 cycles with data_in=1111, then 0011 with en=1 -> no error, phase holds 1 during the gap, phase_vld pulses only twice.
- Saturation (ERR_CNT_WID=2, macro on): 5 consecutive illegal samples -> err_cnt 1, 2, 3, 3, 3. With the macro off, err_cnt stays 0 while seq_err still pulses 5 times.
- Reset mid-stream: assert rst with en=1 and an illegal data_in -> next cycle every output is 0. The first legal sample after reset (0111) gives phase=3 and no seq_err.
